// File: rtl/align_pkg.sv
// Shared constants and types for the local-alignment traceback path.
package align_pkg;

    localparam int unsigned SEQ_LENGTH      = 32;
    localparam int unsigned NUM_PE_IN_PU    = 4;
    localparam int unsigned DIAGONAL_LENGTH = SEQ_LENGTH / 2;
    localparam int unsigned NUM_DIAGONALS   = 2 * DIAGONAL_LENGTH - 1;

    localparam int unsigned COORD_W    = $clog2(SEQ_LENGTH);
    localparam int unsigned DIAG_W     = $clog2(NUM_DIAGONALS);
    localparam int unsigned PU_W       = $clog2(DIAGONAL_LENGTH);
    localparam int unsigned PE_W       = $clog2(NUM_PE_IN_PU);
    localparam int unsigned PATH_LEN_W = 6;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        DIR_STOP = 2'b00,
        DIR_DIAG = 2'b01,
        DIR_UP   = 2'b10,
        DIR_LEFT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } tb_state_t;

    // True when the move would step off the top or left edge of the grid.
    function automatic logic move_hits_edge(dir_t d, coord_t row, coord_t col);
        logic row_zero;
        logic col_zero;
        row_zero = (row == '0);
        col_zero = (col == '0);
        case (d)
            DIR_DIAG: move_hits_edge = row_zero || col_zero;
            DIR_UP:   move_hits_edge = row_zero;
            DIR_LEFT: move_hits_edge = col_zero;
            default:  move_hits_edge = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/cell_addr_map.sv
// Maps a grid cell (row, col) onto the PU diagonal, PU index and PE slot
// of the 2x2-PE array; also used for score-memory addressing.
module cell_addr_map
    import align_pkg::*;
(
    input  coord_t              i_row,
    input  coord_t              i_col,
    output logic [DIAG_W-1:0]   o_diag,
    output logic [PU_W-1:0]     o_pu,
    output logic [PE_W-1:0]     o_pe
);

    assign o_diag = DIAG_W'(i_row >> 1) + DIAG_W'(i_col >> 1);
    assign o_pu   = PU_W'(i_row >> 1);
    assign o_pe   = {i_row[0], i_col[0]};

endmodule

// File: rtl/traceback_walker.sv
// Walks the alignment path backwards from the max-score cell, reading one
// direction code per cell and streaming each step over valid/ready.
module traceback_walker
    import align_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_of_traceback,
    input  logic [COORD_W-1:0]    max_row,
    input  logic [COORD_W-1:0]    max_col,
    input  logic                  abort,
    output logic                  rd_en,
    output logic [DIAG_W-1:0]     choose_diagonal,
    output logic [PU_W-1:0]       choose_pu,
    output logic [PE_W-1:0]       choose_pe,
    input  logic [1:0]            dir_in,
    output logic                  step_vld,
    input  logic                  step_rdy,
    output logic [1:0]            step_dir,
    output logic [COORD_W-1:0]    step_row,
    output logic [COORD_W-1:0]    step_col,
    output logic [COORD_W-1:0]    next_row,
    output logic [COORD_W-1:0]    next_col,
    output logic                  busy,
    output logic                  finished,
    output logic [PATH_LEN_W-1:0] path_len
);

    tb_state_t              r_state;
    coord_t                 r_cur_row;
    coord_t                 r_cur_col;
    dir_t                   r_dir_q;
    logic [PATH_LEN_W-1:0]  r_path_len;
    logic                   r_rd_en;
    logic                   r_step_vld;
    logic                   r_busy;
    logic                   r_finished;

    dir_t                   w_dir_in;
    logic                   w_hits_edge;

    assign w_dir_in    = dir_t'(dir_in);
    assign w_hits_edge = move_hits_edge(r_dir_q, r_cur_row, r_cur_col);

    cell_addr_map u_cell_addr_map (
        .i_row  (r_cur_row),
        .i_col  (r_cur_col),
        .o_diag (choose_diagonal),
        .o_pu   (choose_pu),
        .o_pe   (choose_pe)
    );

    // Sequencer: RD -> CAP -> EMIT per cell; abort overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cur_row  <= '0;
            r_cur_col  <= '0;
            r_dir_q    <= DIR_STOP;
            r_path_len <= '0;
            r_rd_en    <= 1'b0;
            r_step_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
        end else if (abort) begin
            r_state    <= IDLE;
            r_rd_en    <= 1'b0;
            r_step_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_finished <= 1'b0;
                    if (start_of_traceback) begin
                        r_cur_row  <= max_row;
                        r_cur_col  <= max_col;
                        r_path_len <= '0;
                        r_rd_en    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= RD;
                    end
                end
                RD: begin
                    r_rd_en <= 1'b0;
                    r_state <= CAP;
                end
                CAP: begin
                    r_dir_q <= w_dir_in;
                    if (w_dir_in == DIR_STOP) begin
                        r_finished <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_step_vld <= 1'b1;
                        r_state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (step_rdy) begin
                        r_step_vld <= 1'b0;
                        if (r_path_len != '1) begin
                            r_path_len <= r_path_len + PATH_LEN_W'(1);
                        end
                        if (w_hits_edge) begin
                            r_finished <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            if (r_dir_q != DIR_LEFT) begin
                                r_cur_row <= r_cur_row - COORD_W'(1);
                            end
                            if (r_dir_q != DIR_UP) begin
                                r_cur_col <= r_cur_col - COORD_W'(1);
                            end
                            r_rd_en <= 1'b1;
                            r_state <= RD;
                        end
                    end
                end
                DONE: begin
                    r_finished <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_rd_en    <= 1'b0;
                    r_step_vld <= 1'b0;
                    r_busy     <= 1'b0;
                    r_finished <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign rd_en    = r_rd_en;
    assign step_vld = r_step_vld;
    assign step_dir = r_dir_q;
    assign step_row = r_cur_row;
    assign step_col = r_cur_col;
    assign next_row = r_cur_row;
    assign next_col = r_cur_col;
    assign busy     = r_busy;
    assign finished = r_finished;
    assign path_len = r_path_len;

endmodule

// File: tb/tb_traceback_walker.sv
// Randomized self-checking bench for traceback_walker against a path-walk model.
module tb_traceback_walker;

    logic        clk;
    logic        rst_n;
    logic        start_of_traceback;
    logic [4:0]  max_row;
    logic [4:0]  max_col;
    logic        abort;
    logic        rd_en;
    logic [4:0]  choose_diagonal;
    logic [3:0]  choose_pu;
    logic [1:0]  choose_pe;
    logic [1:0]  dir_in;
    logic        step_vld;
    logic        step_rdy;
    logic [1:0]  step_dir;
    logic [4:0]  step_row;
    logic [4:0]  step_col;
    logic [4:0]  next_row;
    logic [4:0]  next_col;
    logic        busy;
    logic        finished;
    logic [5:0]  path_len;

    traceback_walker dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_of_traceback (start_of_traceback),
        .max_row            (max_row),
        .max_col            (max_col),
        .abort              (abort),
        .rd_en              (rd_en),
        .choose_diagonal    (choose_diagonal),
        .choose_pu          (choose_pu),
        .choose_pe          (choose_pe),
        .dir_in             (dir_in),
        .step_vld           (step_vld),
        .step_rdy           (step_rdy),
        .step_dir           (step_dir),
        .step_row           (step_row),
        .step_col           (step_col),
        .next_row           (next_row),
        .next_col           (next_col),
        .busy               (busy),
        .finished           (finished),
        .path_len           (path_len)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  grid [32][32];
    logic [11:0] exp_q [$];
    logic [11:0] obs_q [$];
    int          rd_cyc_q [$];
    int          rd_addr_q [$];
    int          cyc = 0;
    int          fin_count = 0;
    int          fin_cyc = 0;
    int          rd_count = 0;
    int          base_rd, base_fin, base_obs;
    int          rdy_mode = 1;
    int          stall_pct = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Consumer ready: forced low or random with a stall percentage.
    initial begin
        step_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) step_rdy = 1'b0;
            else               step_rdy = ($urandom_range(0, 99) >= stall_pct);
        end
    end

    // Direction storage: decode the requested cell from the address and answer next cycle.
    initial begin
        int rr, cc;
        dir_in = 2'b00;
        forever begin
            @(negedge clk);
            if (rst_n && rd_en) begin
                rr = int'(choose_pu) * 2 + int'(choose_pe[1]);
                cc = (int'(choose_diagonal) - int'(choose_pu)) * 2 + int'(choose_pe[0]);
                @(posedge clk);
                #1;
                if (rr >= 0 && rr < 32 && cc >= 0 && cc < 32) dir_in = grid[rr][cc];
                else                                          dir_in = 2'b00;
            end
        end
    end

    // Observer: records reads, handshakes and finished pulses.
    initial begin
        int nr, nc, exp_addr;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (rd_en) begin
                    rd_count++;
                    rd_cyc_q.push_back(cyc);
                    rd_addr_q.push_back(int'({choose_diagonal, choose_pu, choose_pe}));
                    nr = int'(next_row);
                    nc = int'(next_col);
                    exp_addr = ((nr / 2 + nc / 2) << 6) | ((nr / 2) << 2) | ((nr % 2) << 1) | (nc % 2);
                    check_eq("addr_map", 64'({choose_diagonal, choose_pu, choose_pe}), 64'(exp_addr));
                end
                if (step_vld && step_rdy) obs_q.push_back({step_row, step_col, step_dir});
                if (finished) begin
                    fin_count++;
                    fin_cyc = cyc;
                end
            end
        end
    end

    task automatic fill_grid(input int randomize_it);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                if (randomize_it == 0)                  grid[r][c] = 2'b01;
                else if ($urandom_range(0, 99) < 4)     grid[r][c] = 2'b00;
                else                                    grid[r][c] = 2'($urandom_range(1, 3));
    endtask

    // Reference: follow the direction codes from the start cell until STOP or the grid edge.
    task automatic build_expected(input int r0, input int c0);
        int r, c;
        logic [1:0] d;
        exp_q.delete();
        r = r0;
        c = c0;
        forever begin
            d = grid[r][c];
            if (d == 2'b00) break;
            exp_q.push_back({5'(r), 5'(c), d});
            if ((d == 2'b01 && (r == 0 || c == 0)) || (d == 2'b10 && r == 0) || (d == 2'b11 && c == 0))
                break;
            if (d == 2'b01) begin r--; c--; end
            else if (d == 2'b10) r--;
            else c--;
        end
    endtask

    task automatic mark_base();
        base_rd  = rd_count;
        base_fin = fin_count;
        base_obs = obs_q.size();
    endtask

    task automatic do_start(input int r, input int c);
        @(posedge clk);
        #2;
        max_row = 5'(r);
        max_col = 5'(c);
        start_of_traceback = 1'b1;
        @(posedge clk);
        #2;
        start_of_traceback = 1'b0;
    endtask

    task automatic wait_finish();
        int n = 0;
        while (fin_count == base_fin && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("finish_seen", 64'(fin_count - base_fin), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_vld();
        int n = 0;
        while (!step_vld && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("vld_seen", 64'(step_vld), 64'd1);
    endtask

    task automatic compare_path();
        int ne, no, lim;
        ne  = exp_q.size();
        no  = obs_q.size() - base_obs;
        lim = (ne < no) ? ne : no;
        check_eq("n_steps", 64'(no), 64'(ne));
        for (int i = 0; i < lim; i++)
            check_eq("step", 64'(obs_q[base_obs + i]), 64'(exp_q[i]));
        check_eq("path_len", 64'(path_len), 64'((ne > 63) ? 63 : ne));
        check_eq("path_len_max", 64'(path_len <= 6'd63), 64'd1);
        check_eq("fin_count", 64'(fin_count - base_fin), 64'd1);
        check_eq("busy_after", 64'(busy), 64'd0);
    endtask

    task automatic run_path(input int r, input int c);
        build_expected(r, c);
        mark_base();
        do_start(r, c);
        wait_finish();
        compare_path();
    endtask

    initial begin
        int r, c;
        rst_n = 1'b0;
        start_of_traceback = 1'b0;
        max_row = '0;
        max_col = '0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_outs", 64'({rd_en, choose_diagonal, choose_pu, choose_pe, step_vld, step_dir,
                 step_row, step_col, next_row, next_col, busy, finished, path_len}), 64'd0);

        // All-DIAG from (2,2): three steps, 9 cycles first read to finished.
        fill_grid(0);
        rdy_mode = 1; stall_pct = 0;
        run_path(2, 2);
        check_eq("t1_len", 64'(path_len), 64'd3);
        check_eq("t1_latency", 64'(fin_cyc - rd_cyc_q[base_rd]), 64'd9);

        // STOP on first read of (13,6).
        fill_grid(0);
        grid[13][6] = 2'b00;
        run_path(13, 6);
        check_eq("t2_addr", 64'(rd_addr_q[base_rd]), 64'((9 << 6) | (6 << 2) | 2));
        check_eq("t2_reads", 64'(rd_count - base_rd), 64'd1);
        check_eq("t2_len", 64'(path_len), 64'd0);

        // LEFT then UPs down column 0, ending with UP at (0,0).
        fill_grid(0);
        grid[3][1] = 2'b11;
        grid[3][0] = 2'b10;
        grid[2][0] = 2'b10;
        grid[1][0] = 2'b10;
        grid[0][0] = 2'b10;
        run_path(3, 1);
        check_eq("t3_len", 64'(path_len), 64'd5);

        // Backpressure on the first step.
        fill_grid(0);
        @(posedge clk); #2 rdy_mode = 0;
        build_expected(5, 7);
        mark_base();
        do_start(5, 7);
        wait_vld();
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_vld", 64'(step_vld), 64'd1);
            check_eq("bp_fields", 64'({step_row, step_col, step_dir}), 64'(exp_q[0]));
            check_eq("bp_reads", 64'(rd_count - base_rd), 64'd1);
            @(negedge clk);
        end
        @(posedge clk); #2 rdy_mode = 1; stall_pct = 0;
        wait_finish();
        compare_path();

        // Abort while a step is pending.
        @(posedge clk); #2 rdy_mode = 0;
        mark_base();
        do_start(20, 9);
        wait_vld();
        @(posedge clk); #2 abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        @(negedge clk);
        check_eq("abort_vld", 64'(step_vld), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_len", 64'(path_len), 64'd0);
        repeat (5) @(negedge clk);
        check_eq("abort_no_fin", 64'(fin_count - base_fin), 64'd0);

        // Abort and start together while idle: stays idle.
        @(posedge clk); #2 abort = 1'b1; start_of_traceback = 1'b1;
        @(posedge clk); #2 abort = 1'b0; start_of_traceback = 1'b0;
        @(negedge clk);
        check_eq("abort_start_busy", 64'(busy), 64'd0);

        // Start while busy is ignored.
        @(posedge clk); #2 rdy_mode = 1; stall_pct = 0;
        build_expected(9, 4);
        mark_base();
        do_start(9, 4);
        for (int n = 0; n < 200 && rd_count - base_rd < 2; n++) @(negedge clk);
        do_start(25, 25);
        @(negedge clk);
        check_eq("busy_start_cur", 64'({next_row, next_col}), 64'({5'd8, 5'd3}));
        check_eq("busy_start_len", 64'(path_len), 64'd1);
        wait_finish();
        compare_path();

        // Reset mid-path, then a full diagonal from the far corner.
        mark_base();
        do_start(17, 12);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("reset_mid", 64'({rd_en, choose_diagonal, choose_pu, choose_pe, step_vld, step_dir,
                 step_row, step_col, next_row, next_col, busy, finished, path_len}), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        run_path(31, 31);
        check_eq("t6_len", 64'(path_len), 64'd32);

        // Random grids, starts and backpressure.
        for (int t = 0; t < 20; t++) begin
            fill_grid(1);
            stall_pct = $urandom_range(0, 60);
            r = $urandom_range(0, 31);
            c = $urandom_range(0, 31);
            run_path(r, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
